mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the unified (Von-Neumann) memory build. It is the next generation of the CPU/memory top-level wiring. It serialises the CPU instruction-fetch port and data port onto a single synchronous single-port RAM, and returns per-port ready strobes so the CPU can stall. Arbitration mode, address/data widths and memory read latency are parametrised, so the same block serves the unified build and future shared-bus variants.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter_rr_arbiter2.sv | 60 ++++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the two-port to one-port memory arbiter:
//   ARB_FIXED / ARB_RR   arbitration mode selectors
//   ST_IDLE / ST_BUSY    FSM state encodings
//   CNT_W                latency counter width (MEM_LAT is 1..4)
//   port_e               identifies the instruction or the data port
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam int CNT_W = 3;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU instruction port (i*), the CPU data port (d*) and the RAM
// port (m*) of the memory arbiter.
//   modport slave  : the arbiter (takes requests, drives readies and the RAM)
//   modport master : the environment (CPU requesters plus the RAM read data)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int MASK_W = DATA_W / 8;

   logic              iReq;
   logic [ADDR_W-1:0] iAddr;
   logic              iRdy;
   logic [DATA_W-1:0] iRead;

   logic              dReq;
   logic              dWE;
   logic [MASK_W-1:0] dMask;
   logic [ADDR_W-1:0] dAddr;
   logic [DATA_W-1:0] dWrite;
   logic              dRdy;
   logic [DATA_W-1:0] dRead;

   logic              mEn;
   logic              mWE;
   logic [MASK_W-1:0] mMask;
   logic [ADDR_W-1:0] mAddr;
   logic [DATA_W-1:0] mWrite;
   logic [DATA_W-1:0] mRead;

   modport slave (
      input  iReq, iAddr, dReq, dWE, dMask, dAddr, dWrite, mRead,
      output iRdy, iRead, dRdy, dRead, mEn, mWE, mMask, mAddr, mWrite
   );

   modport master (
      output iReq, iAddr, dReq, dWE, dMask, dAddr, dWrite, mRead,
      input  iRdy, iRead, dRdy, dRead, mEn, mWE, mMask, mAddr, mWrite
   );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester arbiter producing a one-hot grant (bit 0 = instruction,
// bit 1 = data). With mode=0 data always wins contention; with mode=1 the
// port that was not granted last wins. The last-grant flop updates on every
// grant and resets to "data" so the first round-robin contention goes to the
// instruction port.
// Ports: clk, reset (sync, active-low), en (a grant may issue this cycle),
//        mode, req_i, req_d, grant[1:0].
// -----------------------------------------------------------------------------
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       mode,
   input  logic       req_i,
   input  logic       req_d,
   output logic [1:0] grant
);

   port_e last_grant_q;
   port_e last_grant_d;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req_i && req_d) begin
            if (mode && (last_grant_q == PORT_DATA)) begin
               grant = 2'b01;
            end else begin
               grant = 2'b10;
            end
         end else if (req_d) begin
            grant = 2'b10;
         end else if (req_i) begin
            grant = 2'b01;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant[1]) begin
         last_grant_d = PORT_DATA;
      end else if (grant[0]) begin
         last_grant_d = PORT_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_q <= PORT_DATA;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises the CPU instruction-fetch and data ports onto one synchronous
// single-port RAM with read latency MEM_LAT.
// Ports: clk, reset (sync, active-low), bus (mem_arbiter_if.slave) carrying
//        the i*, d* and m* signal groups.
// A grant is combinational in the cycle it is issued (mEn=1 with the granted
// port's address/data muxed onto the RAM), and the owner's ready strobe
// fires MEM_LAT cycles later with the RAM read data passed straight through.
// In the ready cycle a new grant may issue; a requester that keeps Req high
// through its ready strobe is presenting its next access, which gives one
// access per MEM_LAT cycles on a single port.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ARB_MODE = ARB_FIXED,
   parameter int MEM_LAT  = 1
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam int MASK_W = DATA_W / 8;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   port_e            owner_q, owner_d;

   logic       ready;
   logic       arb_en;
   logic [1:0] grant;

   // Every output is gated with reset so the block is silent while reset is
   // low, including the cycle in which reset is first asserted mid-access.
   assign ready  = reset && (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
   assign arb_en = reset && ((state_q == ST_IDLE) || ready);

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .mode  (ARB_MODE == ARB_RR),
      .req_i (bus.iReq),
      .req_d (bus.dReq),
      .grant (grant)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      if (state_q == ST_BUSY) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end
      if (grant != 2'b00) begin
         state_d = ST_BUSY;
         cnt_d   = CNT_W'(MEM_LAT);
         owner_d = grant[1] ? PORT_DATA : PORT_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= PORT_INSTR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

   // RAM-side mux: instruction grants are always full-word reads.
   always_comb begin
      bus.mEn    = 1'b0;
      bus.mWE    = 1'b0;
      bus.mMask  = {MASK_W{1'b0}};
      bus.mAddr  = {ADDR_W{1'b0}};
      bus.mWrite = {DATA_W{1'b0}};
      if (grant[1]) begin
         bus.mEn    = 1'b1;
         bus.mWE    = bus.dWE;
         bus.mMask  = bus.dMask;
         bus.mAddr  = bus.dAddr;
         bus.mWrite = bus.dWrite;
      end else if (grant[0]) begin
         bus.mEn    = 1'b1;
         bus.mMask  = {MASK_W{1'b1}};
         bus.mAddr  = bus.iAddr;
      end
   end

   // Return side: only the owner of the finishing access sees a strobe.
   always_comb begin
      bus.iRdy  = ready && (owner_q == PORT_INSTR);
      bus.dRdy  = ready && (owner_q == PORT_DATA);
      bus.iRead = bus.iRdy ? bus.mRead : {DATA_W{1'b0}};
      bus.dRead = bus.dRdy ? bus.mRead : {DATA_W{1'b0}};
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Four arbiter configurations share one stimulus stream, each with its own
// behavioural RAM (latency MEM_LAT, byte-masked writes):
//   cfg0: fixed priority, MEM_LAT=1   cfg1: round-robin, MEM_LAT=1
//   cfg2: fixed priority, MEM_LAT=2   cfg3: fixed priority, MEM_LAT=3
// RAM words are preset to 0xA0000000 | byte_address.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        ram_init;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_write;
   logic [3:0]  d_mask;

   logic [3:0]  i_rdy_v, d_rdy_v, m_en_v, m_we_v;
   logic [31:0] i_read_a  [4];
   logic [31:0] d_read_a  [4];
   logic [31:0] m_addr_a  [4];
   logic [31:0] m_write_a [4];
   logic [3:0]  m_mask_a  [4];

   int n_chk  = 0;
   int n_fail = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cfg
         localparam int LAT  = (gi == 3) ? 3 : ((gi == 2) ? 2 : 1);
         localparam int MODE = (gi == 1) ? 1 : 0;

         mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

         mem_arbiter #(
            .ADDR_W   (32),
            .DATA_W   (32),
            .ARB_MODE (MODE),
            .MEM_LAT  (LAT)
         ) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus)
         );

         logic [31:0] mem     [0:1023];
         logic [31:0] rd_pipe [0:3];

         always @(posedge clk) begin
            if (ram_init) begin
               for (int k = 0; k < 1024; k++) begin
                  mem[k] <= 32'hA000_0000 | (32'(k) << 2);
               end
            end else if (bus.mEn && bus.mWE) begin
               for (int b = 0; b < 4; b++) begin
                  if (bus.mMask[b]) begin
                     mem[bus.mAddr[11:2]][8*b +: 8] <= bus.mWrite[8*b +: 8];
                  end
               end
            end
            if (bus.mEn) begin
               rd_pipe[0] <= mem[bus.mAddr[11:2]];
            end
            for (int s = 1; s < 4; s++) begin
               rd_pipe[s] <= rd_pipe[s-1];
            end
         end

         assign bus.iReq   = i_req;
         assign bus.iAddr  = i_addr;
         assign bus.dReq   = d_req;
         assign bus.dWE    = d_we;
         assign bus.dMask  = d_mask;
         assign bus.dAddr  = d_addr;
         assign bus.dWrite = d_write;
         assign bus.mRead  = rd_pipe[LAT-1];

         assign i_rdy_v[gi]   = bus.iRdy;
         assign d_rdy_v[gi]   = bus.dRdy;
         assign m_en_v[gi]    = bus.mEn;
         assign m_we_v[gi]    = bus.mWE;
         assign i_read_a[gi]  = bus.iRead;
         assign d_read_a[gi]  = bus.dRead;
         assign m_addr_a[gi]  = bus.mAddr;
         assign m_write_a[gi] = bus.mWrite;
         assign m_mask_a[gi]  = bus.mMask;
      end
   endgenerate

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, obs);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Two reset-low cycles with requests dropped, then one idle cycle.
   task automatic do_reset();
      next_cycle();
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   initial begin
      rst_n    = 1'b0;
      ram_init = 1'b1;
      i_req    = 1'b1;
      d_req    = 1'b1;
      d_we     = 1'b0;
      i_addr   = 32'h40;
      d_addr   = 32'h80;
      d_mask   = 4'h0;
      d_write  = 32'h0;
      next_cycle();
      ram_init = 1'b0;

      // Requests held while reset is low: nothing may be granted.
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         check_eq($sformatf("rst_men%0d", c), {31'd0, m_en_v[c]}, 32'd0);
         check_eq($sformatf("rst_rdy%0d", c), {30'd0, i_rdy_v[c], d_rdy_v[c]}, 32'd0);
         check_eq($sformatf("rst_maddr%0d", c), m_addr_a[c], 32'd0);
      end
      next_cycle();
      i_req = 1'b0;
      d_req = 1'b0;
      rst_n = 1'b1;
      next_cycle();

      // Single fetch, cfg0 (MEM_LAT=1).
      i_req  = 1'b1;
      i_addr = 32'h40;
      @(negedge clk);
      check_eq("fetch_men",   {31'd0, m_en_v[0]}, 32'd1);
      check_eq("fetch_maddr", m_addr_a[0], 32'h40);
      check_eq("fetch_mwe",   {31'd0, m_we_v[0]}, 32'd0);
      check_eq("fetch_mmask", {28'd0, m_mask_a[0]}, 32'hF);
      check_eq("fetch_irdy0", {31'd0, i_rdy_v[0]}, 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("fetch_irdy1", {31'd0, i_rdy_v[0]}, 32'd1);
      check_eq("fetch_iread", i_read_a[0], 32'hA000_0040);
      check_eq("fetch_drdy1", {31'd0, d_rdy_v[0]}, 32'd0);
      do_reset();

      // Both ports requesting: cfg0 fixed priority, cfg1 round-robin.
      i_req  = 1'b1;
      d_req  = 1'b1;
      i_addr = 32'h40;
      d_addr = 32'h80;
      d_we   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 4) begin
            check_eq($sformatf("fix_maddr%0d", k), m_addr_a[0], 32'h80);
            check_eq($sformatf("rr_maddr%0d", k), m_addr_a[1], (k % 2 == 0) ? 32'h40 : 32'h80);
         end
         check_eq($sformatf("fix_irdy%0d", k), {31'd0, i_rdy_v[0]}, 32'd0);
         check_eq($sformatf("fix_drdy%0d", k), {31'd0, d_rdy_v[0]}, (k > 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("rr_irdy%0d", k), {31'd0, i_rdy_v[1]}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check_eq($sformatf("rr_drdy%0d", k), {31'd0, d_rdy_v[1]}, (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
         if (k > 0) begin
            check_eq($sformatf("fix_dread%0d", k), d_read_a[0], 32'hA000_0080);
            check_eq($sformatf("rr_read%0d", k), (k % 2 == 1) ? i_read_a[1] : d_read_a[1],
                     (k % 2 == 1) ? 32'hA000_0040 : 32'hA000_0080);
         end
         next_cycle();
      end
      do_reset();

      // Full write, masked write, read back (cfg0).
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_mask  = 4'hF;
      d_addr  = 32'h100;
      d_write = 32'h1122_3344;
      @(negedge clk);
      check_eq("wr_mwe",    {31'd0, m_we_v[0]}, 32'd1);
      check_eq("wr_mmask",  {28'd0, m_mask_a[0]}, 32'hF);
      check_eq("wr_mwrite", m_write_a[0], 32'h1122_3344);
      check_eq("wr_maddr",  m_addr_a[0], 32'h100);
      next_cycle();
      @(negedge clk);
      check_eq("wr_drdy", {31'd0, d_rdy_v[0]}, 32'd1);
      next_cycle();
      d_mask  = 4'b0011;
      d_write = 32'hAABB_CCDD;
      @(negedge clk);
      check_eq("mwr_mmask",  {28'd0, m_mask_a[0]}, 32'h3);
      check_eq("mwr_mwrite", m_write_a[0], 32'hAABB_CCDD);
      check_eq("mwr_drdy",   {31'd0, d_rdy_v[0]}, 32'd1);
      next_cycle();
      d_we = 1'b0;
      @(negedge clk);
      check_eq("rd_mwe",  {31'd0, m_we_v[0]}, 32'd0);
      check_eq("rd_drdy_w", {31'd0, d_rdy_v[0]}, 32'd1);
      next_cycle();
      @(negedge clk);
      check_eq("rd_drdy",  {31'd0, d_rdy_v[0]}, 32'd1);
      check_eq("rd_dread", d_read_a[0], 32'h1122_CCDD);
      do_reset();

      // Reset during an outstanding fetch (cfg3, MEM_LAT=3).
      i_req  = 1'b1;
      i_addr = 32'h40;
      @(negedge clk);
      check_eq("rstmid_men", {31'd0, m_en_v[3]}, 32'd1);
      next_cycle();
      rst_n = 1'b0;
      i_req = 1'b0;
      @(negedge clk);
      check_eq("rstmid_men1",  {31'd0, m_en_v[3]}, 32'd0);
      check_eq("rstmid_irdy1", {31'd0, i_rdy_v[3]}, 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("rstmid_men2",   {31'd0, m_en_v[3]}, 32'd0);
      check_eq("rstmid_mwe2",   {31'd0, m_we_v[3]}, 32'd0);
      check_eq("rstmid_rdy2",   {30'd0, i_rdy_v[3], d_rdy_v[3]}, 32'd0);
      check_eq("rstmid_maddr2", m_addr_a[3], 32'd0);
      check_eq("rstmid_mmask2", {28'd0, m_mask_a[3]}, 32'd0);
      check_eq("rstmid_iread2", i_read_a[3], 32'd0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rstmid_irdy3", {31'd0, i_rdy_v[3]}, 32'd0);
      do_reset();

      // Back-to-back data reads (cfg2, MEM_LAT=2).
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0;
      @(negedge clk);
      check_eq("b2b_men0",   {31'd0, m_en_v[2]}, 32'd1);
      check_eq("b2b_maddr0", m_addr_a[2], 32'h0);
      next_cycle();
      @(negedge clk);
      check_eq("b2b_men1",  {31'd0, m_en_v[2]}, 32'd0);
      check_eq("b2b_drdy1", {31'd0, d_rdy_v[2]}, 32'd0);
      next_cycle();
      d_addr = 32'h4;
      @(negedge clk);
      check_eq("b2b_drdy2",  {31'd0, d_rdy_v[2]}, 32'd1);
      check_eq("b2b_dread2", d_read_a[2], 32'hA000_0000);
      check_eq("b2b_men2",   {31'd0, m_en_v[2]}, 32'd1);
      check_eq("b2b_maddr2", m_addr_a[2], 32'h4);
      next_cycle();
      @(negedge clk);
      check_eq("b2b_drdy3", {31'd0, d_rdy_v[2]}, 32'd0);
      check_eq("b2b_men3",  {31'd0, m_en_v[2]}, 32'd0);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check_eq("b2b_drdy4",  {31'd0, d_rdy_v[2]}, 32'd1);
      check_eq("b2b_dread4", d_read_a[2], 32'hA000_0004);
      check_eq("b2b_men4",   {31'd0, m_en_v[2]}, 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("b2b_drdy5",  {31'd0, d_rdy_v[2]}, 32'd0);
      check_eq("b2b_dread5", d_read_a[2], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
